// File: rtl/disp_pkg.sv
// disp_pkg: colour codes, glyph geometry and BCD-to-segment decode shared by the display pipe
package disp_pkg;
  localparam logic [1:0] COL_NONE  = 2'd0;
  localparam logic [1:0] COL_FIELD = 2'd1;
  localparam logic [1:0] COL_OBJ   = 2'd2;
  localparam logic [1:0] COL_SCORE = 2'd3;
  localparam int GLYPH_W     = 48;
  localparam int GLYPH_H     = 88;
  localparam int SEG_T       = 8;
  localparam int GLYPH_TOP   = 16;
  localparam int GLYPH_X0    = 56;
  localparam int GLYPH_PITCH = 56;
  localparam logic [6:0] SEG_ERR = 7'h76;
  typedef enum logic {IDLE, FLASH} flash_t;
  function automatic logic [6:0] bcd_seg(input logic [3:0] d);
    case (d)
      4'd0: bcd_seg = 7'h3f;
      4'd1: bcd_seg = 7'h06;
      4'd2: bcd_seg = 7'h5b;
      4'd3: bcd_seg = 7'h4f;
      4'd4: bcd_seg = 7'h66;
      4'd5: bcd_seg = 7'h6d;
      4'd6: bcd_seg = 7'h7d;
      4'd7: bcd_seg = 7'h07;
      4'd8: bcd_seg = 7'h7f;
      4'd9: bcd_seg = 7'h6f;
      default: bcd_seg = SEG_ERR;
    endcase
  endfunction
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: tests whether a raster pixel falls on a lit segment of one seven-segment glyph box
module seg7_glyph (
  input  logic [9:0] h,
  input  logic [9:0] v,
  input  logic [9:0] ox,
  input  logic [9:0] oy,
  input  logic [6:0] seg,
  output logic       hit
);
  import disp_pkg::*;
  localparam logic [10:0] W  = 11'(GLYPH_W);
  localparam logic [10:0] H  = 11'(GLYPH_H);
  localparam logic [10:0] T  = 11'(SEG_T);
  localparam logic [10:0] MT = 11'((GLYPH_H - SEG_T) / 2);
  localparam logic [10:0] MB = 11'((GLYPH_H + SEG_T) / 2);
  logic [10:0] dx, dy;
  logic [6:0] on;
  // segment rectangles a..g in box-local coordinates, masked by the digit's segment set
  always_comb begin
    dx = {1'b0, h} - {1'b0, ox};
    dy = {1'b0, v} - {1'b0, oy};
    on[0] = dy < T;
    on[1] = dx >= W - T && dy < MB;
    on[2] = dx >= W - T && dy >= MT;
    on[3] = dy >= H - T;
    on[4] = dx < T && dy >= MT;
    on[5] = dx < T && dy < MB;
    on[6] = dy >= MT && dy < MB;
    hit = h >= ox && v >= oy && dx < W && dy < H && |(on & seg);
  end
endmodule

// File: rtl/disp_pipe.sv
// disp_pipe: two-stage pixel renderer for a pong playfield with frame-latched inputs and score flashing
module disp_pipe
  import disp_pkg::*;
#(
  parameter int H_VIS        = 640,
  parameter int V_VIS        = 480,
  parameter int FIELD_TOP    = 128,
  parameter int FIELD_BOT    = 470,
  parameter int BALL_SZ      = 8,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 48,
  parameter int PAD_X        = 16,
  parameter int DIGITS       = 1,
  parameter int FLASH_FRAMES = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [19:0]         ball,
  input  logic [19:0]         ppos,
  input  logic [8*DIGITS-1:0] score,
  input  logic [9:0]          hcnt,
  input  logic [9:0]          vcnt,
  output logic                draw,
  output logic [1:0]          color,
  output logic [1:0]          flash_busy
);
  localparam int CW = $clog2(FLASH_FRAMES + 1) < 4 ? 4 : $clog2(FLASH_FRAMES + 1);
  localparam int SW = 4 * DIGITS;
  localparam logic [10:0] FT  = 11'(FIELD_TOP);
  localparam logic [10:0] FB  = 11'(FIELD_BOT);
  localparam logic [10:0] HM  = 11'(H_VIS / 2);
  localparam logic [10:0] BS  = 11'(BALL_SZ);
  localparam logic [10:0] PH  = 11'(PAD_H);
  localparam logic [10:0] LX0 = 11'(PAD_X);
  localparam logic [10:0] LX1 = 11'(PAD_X + PAD_W);
  localparam logic [10:0] RX0 = 11'(H_VIS - PAD_X - PAD_W);
  localparam logic [10:0] RX1 = 11'(H_VIS - PAD_X);
  localparam logic [10:0] HV  = 11'(H_VIS);
  localparam logic [10:0] VV  = 11'(V_VIS);
  logic [19:0] ball_s, ppos_s;
  logic [8*DIGITS-1:0] score_s;
  flash_t st [2];
  flash_t st_n [2];
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] cnt_n [2];
  logic armed, latch, vis, f_hit, o_hit, s_hit, f_q, o_q, s_q;
  logic [10:0] h, v, bx, by, pl, pr;
  logic [1:0] hide;
  logic [2*DIGITS-1:0] g_hit;
  // per-player flash FSM; armed suppresses a flash on the first latch after reset
  always_comb begin
    latch = hcnt == 10'd0 && vcnt == 10'(V_VIS);
    for (int i = 0; i < 2; i++) begin
      st_n[i] = st[i];
      cnt_n[i] = cnt[i];
      if (latch && armed && score[i*SW +: SW] != score_s[i*SW +: SW]) begin
        st_n[i] = FLASH;
        cnt_n[i] = CW'(FLASH_FRAMES);
      end else if (latch && st[i] == FLASH) begin
        cnt_n[i] = cnt[i] - CW'(1);
        st_n[i] = cnt[i] == CW'(1) ? IDLE : FLASH;
      end
      hide[i] = st[i] == FLASH && cnt[i][3];
      flash_busy[i] = st[i] == FLASH;
    end
  end
  // shadows and flash state advance only at the start-of-vblank latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= '{IDLE, IDLE};
      cnt <= '{default: '0};
      ball_s <= '0;
      ppos_s <= '0;
      score_s <= '0;
      armed <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      if (latch) begin
        ball_s <= ball;
        ppos_s <= ppos;
        score_s <= score;
        armed <= 1'b1;
      end
    end
  end
  // per-object hit tests in 11 bits so object extents never wrap back onto the screen
  always_comb begin
    h = {1'b0, hcnt};
    v = {1'b0, vcnt};
    bx = {1'b0, ball_s[9:0]};
    by = {1'b0, ball_s[19:10]};
    pl = FT + {1'b0, ppos_s[9:0]};
    pr = FT + {1'b0, ppos_s[19:10]};
    vis = h < HV && v < VV;
    f_hit = v == FT || v == FT + 11'd1 || v == FB || v == FB + 11'd1 ||
            ((h == HM || h == HM + 11'd1) && v > FT + 11'd1 && vcnt[5]);
    o_hit = (h >= bx && h < bx + BS && v >= by && v < by + BS) ||
            (h >= LX0 && h < LX1 && v >= pl && v < pl + PH) ||
            (h >= RX0 && h < RX1 && v >= pr && v < pr + PH);
    s_hit = |g_hit;
  end
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    localparam int LX = GLYPH_X0 + GLYPH_PITCH * k;
    seg7_glyph u_l (
      .h(hcnt), .v(vcnt), .ox(10'(LX)), .oy(10'(GLYPH_TOP)),
      .seg(hide[0] ? 7'd0 : bcd_seg(score_s[4*(DIGITS-1-k) +: 4])),
      .hit(g_hit[2*k])
    );
    seg7_glyph u_r (
      .h(hcnt), .v(vcnt), .ox(10'(H_VIS - LX - GLYPH_W)), .oy(10'(GLYPH_TOP)),
      .seg(hide[1] ? 7'd0 : bcd_seg(score_s[SW + 4*(DIGITS-1-k) +: 4])),
      .hit(g_hit[2*k+1])
    );
  end
  // stage 1: register visibility-gated object hits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_q <= 1'b0;
      o_q <= 1'b0;
      s_q <= 1'b0;
    end else begin
      f_q <= vis && f_hit;
      o_q <= vis && o_hit;
      s_q <= vis && s_hit;
    end
  end
  // stage 2: register the priority merge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color <= COL_NONE;
      draw <= 1'b0;
    end else begin
      color <= s_q ? COL_SCORE : o_q ? COL_OBJ : f_q ? COL_FIELD : COL_NONE;
      draw <= s_q || o_q || f_q;
    end
  end
endmodule

// File: tb/tb_disp_pipe.sv
// tb_disp_pipe: table vectors, directed sequences and random raster probes against a behavioural model
module tb_disp_pipe;
  logic clk = 1'b0, rst = 1'b0, draw;
  logic [19:0] ball = '0, ppos = '0;
  logic [7:0] score = '0;
  logic [9:0] hcnt = '0, vcnt = '0;
  logic [1:0] color, flash_busy;
  int checks = 0, failures = 0;

  disp_pipe dut (
    .clk(clk), .rst(rst), .ball(ball), .ppos(ppos), .score(score),
    .hcnt(hcnt), .vcnt(vcnt), .draw(draw), .color(color), .flash_busy(flash_busy)
  );

  always #5 clk = ~clk;

  int sh_ball = 0, sh_ppos = 0, sh_score = 0;
  bit armed = 0;
  int left [2] = '{0, 0};
  int q [$];
  string dig [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  typedef struct {int bx, by, pl, pr, sc, h, v, c;} vec_t;
  vec_t tbl [$];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit seg_on(byte s, int x, int y);
    case (s)
      "a": return y < 8;
      "b": return x >= 40 && y < 48;
      "c": return x >= 40 && y >= 40;
      "d": return y >= 80;
      "e": return x < 8 && y >= 40;
      "f": return x < 8 && y < 48;
      "g": return y >= 40 && y < 48;
      default: return 0;
    endcase
  endfunction

  function automatic bit glyph(int d, int x, int y);
    string s;
    if (x < 0 || x >= 48 || y < 0 || y >= 88) return 0;
    s = d > 9 ? "bcefg" : dig[d];
    for (int i = 0; i < s.len(); i++) if (seg_on(s[i], x, y)) return 1;
    return 0;
  endfunction

  function automatic int exp_color(int h, int v);
    int c = 0;
    int bx = sh_ball % 1024, by = sh_ball / 1024;
    int pl = 128 + sh_ppos % 1024, pr = 128 + sh_ppos / 1024;
    if (h >= 640 || v >= 480) return 0;
    if (v == 128 || v == 129 || v == 470 || v == 471 || ((h == 320 || h == 321) && v > 129 && (v & 32) != 0)) c = 1;
    if (h >= bx && h < bx + 8 && v >= by && v < by + 8) c = 2;
    if (h >= 16 && h < 24 && v >= pl && v < pl + 48) c = 2;
    if (h >= 616 && h < 624 && v >= pr && v < pr + 48) c = 2;
    for (int p = 0; p < 2; p++)
      if (!(left[p] > 0 && (left[p] & 8) != 0) && glyph((sh_score >> (4 * p)) & 15, h - (p == 0 ? 56 : 536), v - 16)) c = 3;
    return c;
  endfunction

  task automatic model_latch();
    for (int i = 0; i < 2; i++) begin
      if (armed && ((int'(score) >> (4 * i)) & 15) != ((sh_score >> (4 * i)) & 15)) left[i] = 60;
      else if (left[i] > 0) left[i]--;
    end
    sh_ball = int'(ball);
    sh_ppos = int'(ppos);
    sh_score = int'(score);
    armed = 1;
  endtask

  task automatic drive(int h, int v);
    hcnt = 10'(h);
    vcnt = 10'(v);
    q.push_back(exp_color(h, v));
    if (h == 0 && v == 480) model_latch();
  endtask

  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      check("color", int'(color), e);
      check("draw", int'(draw), int'(e != 0));
    end
    check("flash_busy", int'(flash_busy), (left[1] > 0 ? 2 : 0) + (left[0] > 0 ? 1 : 0));
  endtask

  task automatic latch();
    drive(0, 480);
    tick();
  endtask

  task automatic probe(int h, int v, int exp, string name);
    q.delete();
    drive(h, v);
    tick();
    drive(h, v);
    tick();
    check(name, int'(color), exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_color", int'(color), 0);
    check("rst_draw", int'(draw), 0);
    check("rst_busy", int'(flash_busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sh_ball = 0; sh_ppos = 0; sh_score = 0; armed = 0;
    left = '{0, 0};
    q.delete();
  endtask

  task automatic add(int bx, int by, int pl, int pr, int sc, int h, int v, int c);
    vec_t t;
    t = '{bx, by, pl, pr, sc, h, v, c};
    tbl.push_back(t);
  endtask

  task automatic set_in(int bx, int by, int pl, int pr, int sc);
    ball = 20'(by * 1024 + bx);
    ppos = 20'(pr * 1024 + pl);
    score = 8'(sc);
  endtask

  initial begin
    add(100, 200, 0, 100, 'h73, 104, 203, 2); add(100, 200, 0, 100, 'h73, 108, 203, 0);
    add(100, 200, 0, 100, 'h73, 100, 200, 2); add(100, 200, 0, 100, 'h73, 99, 200, 0);
    add(100, 200, 0, 100, 'h73, 107, 207, 2); add(100, 200, 0, 100, 'h73, 107, 208, 0);
    add(100, 200, 0, 100, 'h73, 20, 128, 2);  add(100, 200, 0, 100, 'h73, 20, 175, 2);
    add(100, 200, 0, 100, 'h73, 20, 176, 0);  add(100, 200, 0, 100, 'h73, 50, 129, 1);
    add(100, 200, 0, 100, 'h73, 50, 130, 0);  add(100, 200, 0, 100, 'h73, 50, 471, 1);
    add(100, 200, 0, 100, 'h73, 50, 472, 0);  add(100, 200, 0, 100, 'h73, 321, 160, 1);
    add(100, 200, 0, 100, 'h73, 322, 160, 0); add(100, 200, 0, 100, 'h73, 320, 150, 0);
    add(100, 200, 0, 100, 'h73, 320, 96, 0);  add(100, 200, 0, 100, 'h73, 616, 228, 2);
    add(100, 200, 0, 100, 'h73, 623, 275, 2); add(100, 200, 0, 100, 'h73, 624, 250, 0);
    add(100, 200, 0, 100, 'h73, 70, 20, 3);   add(100, 200, 0, 100, 'h73, 60, 30, 0);
    add(100, 200, 0, 100, 'h73, 100, 30, 3);  add(100, 200, 0, 100, 'h73, 60, 80, 0);
    add(100, 200, 0, 100, 'h73, 100, 80, 3);  add(100, 200, 0, 100, 'h73, 70, 100, 3);
    add(100, 200, 0, 100, 'h73, 540, 20, 3);  add(100, 200, 0, 100, 'h73, 540, 100, 0);
    add(100, 200, 0, 100, 'h73, 640, 128, 0); add(100, 200, 0, 100, 'h73, 50, 480, 0);
    add(100, 200, 0, 100, 'h7C, 70, 20, 0);   add(100, 200, 0, 100, 'h7C, 60, 30, 3);
    add(100, 200, 0, 100, 'h7C, 100, 30, 3);  add(100, 200, 0, 100, 'h7C, 70, 60, 3);
    add(100, 200, 0, 100, 'h7C, 60, 80, 3);   add(100, 200, 0, 100, 'h7C, 100, 80, 3);
    add(100, 200, 0, 100, 'h7C, 70, 100, 0);
    add(1020, 10, 0, 0, 0, 3, 12, 0);         add(200, 1020, 0, 0, 0, 202, 2, 0);
    add(300, 300, 1000, 0, 0, 20, 130, 0);    add(636, 300, 0, 0, 0, 639, 300, 2);
    add(636, 300, 0, 0, 0, 640, 300, 0);      add(60, 16, 0, 0, 'h33, 62, 18, 3);
    add(200, 126, 0, 0, 0, 202, 128, 2);
    for (int i = 0; i < tbl.size(); i++) begin
      do_reset();
      set_in(tbl[i].bx, tbl[i].by, tbl[i].pl, tbl[i].pr, tbl[i].sc);
      latch();
      probe(tbl[i].h, tbl[i].v, tbl[i].c, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_draw", i), int'(draw), int'(tbl[i].c != 0));
    end

    // left score 3 -> 4: 60 flashing frames, left hidden while counter bit 3 is set
    do_reset();
    set_in(100, 200, 0, 100, 'h73);
    latch();
    check("no_flash_first", int'(flash_busy), 0);
    score = 8'h74;
    latch();
    check("flash_start", int'(flash_busy), 1);
    for (int f = 0; f < 60; f++) begin
      probe(100, 30, ((60 - f) & 8) != 0 ? 0 : 3, $sformatf("left_digit_f%0d", f));
      probe(580, 30, 3, $sformatf("right_digit_f%0d", f));
      latch();
      check($sformatf("busy_f%0d", f), int'(flash_busy), (59 - f) > 0 ? 1 : 0);
    end
    probe(100, 30, 3, "left_after_flash");

    // ball moved mid-frame only shows after the next latch
    do_reset();
    set_in(100, 200, 0, 0, 0);
    latch();
    probe(104, 203, 2, "ball_before");
    for (int i = 0; i < 20; i++) begin drive(200 + i * 13, 240); tick(); end
    set_in(300, 300, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin drive(300 + i, 240); tick(); end
    probe(104, 203, 2, "ball_old_kept");
    probe(304, 303, 0, "ball_new_hidden");
    latch();
    probe(304, 303, 2, "ball_new_shown");
    probe(104, 203, 0, "ball_old_gone");

    // reset during a flash clears outputs at once and suppresses the next flash
    do_reset();
    set_in(100, 200, 0, 0, 'h11);
    latch();
    score = 8'h12;
    latch();
    check("flash_before_rst", int'(flash_busy), 1);
    for (int i = 0; i < 8; i++) begin drive(100 + i, 300); tick(); end
    drive(104, 203);
    tick();
    #2;
    do_reset();
    probe(2, 2, 2, "zero_ball");
    probe(70, 20, 3, "zero_score");
    latch();
    check("no_flash_after_rst", int'(flash_busy), 0);
    probe(104, 203, 2, "post_rst_latch");

    // random raster walk with random inputs and frame latches
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int h, v;
      if ($urandom_range(0, 39) == 0)
        set_in($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 420), $urandom_range(0, 420), $urandom_range(0, 255));
      if ($urandom_range(0, 24) == 0) begin
        h = 0; v = 480;
      end else begin
        case ($urandom_range(0, 3))
          0: begin h = $urandom_range(0, 1023); v = $urandom_range(0, 1023); end
          1: begin h = (sh_ball % 1024 + $urandom_range(0, 12) + 1022) % 1024; v = (sh_ball / 1024 + $urandom_range(0, 12) + 1022) % 1024; end
          2: begin h = $urandom_range(40, 600); v = $urandom_range(0, 120); end
          default: begin h = $urandom_range(0, 2) == 0 ? $urandom_range(318, 323) : $urandom_range(0, 1) == 0 ? $urandom_range(14, 25) : $urandom_range(612, 625); v = $urandom_range(120, 480); end
        endcase
      end
      drive(h, v);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
